dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel request resolver for the 8237A-style DMA controller. It synchronizes the four DREQ pins and merges them with the mask and software request registers. It picks one channel under fixed or rotating priority and drives the one-hot `VALID_DREQ` vector that the timing-control FSM consumes. It owns the per-channel DACK pins and the priority pointer. It holds the grant stable from arbitration until the timing control reports the end of the transfer cycle.

## Interface
- `NUM_CH`, 4: number of DMA channels; the design is verified only at 4.
- `CLK` input 1: system clock, rising-edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `DREQ` input NUM_CH: raw channel request pins; asynchronous to `CLK`.
- `maskReg` input NUM_CH: 1 = channel masked; applies to hardware requests only.
- `requestReg` input NUM_CH: software request bits; not masked and not synchronized.
- `cmdDisable` input 1: commandReg[2]; 1 = no new arbitration.
- `cmdRotate` input 1: commandReg[4]; 0 = fixed priority (ch0 highest), 1 = rotating priority.
- `cmdDreqLow` input 1: commandReg[6]; 1 = DREQ pins are active-low.
- `cmdDackHigh` input 1: commandReg[7]; 1 = DACK pins are active-high.
- `dackEn` input 1: single-cycle pulse from timing control when it enters S1 (bus owned).
- `cycleDone` input 1: single-cycle pulse from timing control at the end of S4 or on EOP.
- `tcHit` input 1: qualifies `cycleDone`; terminal count or EOP reached on the active channel.
- `VALID_DREQ` output NUM_CH: one-hot granted channel, registered.
- `DACK` output NUM_CH: acknowledge pins, polarity set by `cmdDackHigh`.
- `activeCh` output 2: index of the granted channel.
- `reqStatus` output NUM_CH: synchronized effective requests, for statusReg[7:4].
- `clrSoftReq` output NUM_CH: single-cycle pulse that clears the `requestReg` bit on TC.

## Operation
- Synchronization: each `DREQ` bit passes through a 2-flop synchronizer. The result is XORed with `cmdDreqLow` to give `hwReq`.
- Effective request: `eff = (hwReq & ~maskReg) | requestReg`. `reqStatus = eff`.
- Priority order: starts at `prioPtr` and ascends modulo 4. Under fixed priority `prioPtr` is held at 0.
- FSM states and transitions:
  - IDLE:
    - Condition: `!cmdDisable && eff != 0`.
    - Action: latch the highest-priority channel into `activeCh`, set `VALID_DREQ` one-hot, go to REQ.
  - REQ:
    - Withdrawal: if `eff[activeCh]` deasserts before `dackEn`, clear `VALID_DREQ` and go to IDLE.
    - Grant: on `dackEn`, go to SVC.
  - SVC:
    - `DACK[activeCh]` is active and `VALID_DREQ` is held.
    - Request changes, mask changes and `cmdDisable` are all ignored.
    - On `cycleDone`, go to DONE.
  - DONE (one cycle):
    - Clear `VALID_DREQ` and DACK.
    - If `cmdRotate`, set `prioPtr <= activeCh + 1` (2-bit wrap, ch3 -> ch0).
    - If `tcHit`, pulse `clrSoftReq[activeCh]`.
    - Go to IDLE.
- `dackEn` outside REQ and `cycleDone` outside SVC are ignored.
- A `requestReg` bit remains a request until it is cleared externally after `clrSoftReq`.
- `DACK = cmdDackHigh ? dackVec : ~dackVec`, where `dackVec` is the registered one-hot for the SVC state.

## Timing
- Reset values:
  - State: IDLE; `prioPtr`: 0; `activeCh`: 0; synchronizers: 0.
  - `VALID_DREQ`: 0; `clrSoftReq`: 0.
  - `DACK`: 4'hF (command inputs are 0 at reset).
- Latency:
  - DREQ pin edge to `VALID_DREQ`: 3 cycles (2 sync + 1 registered arbitration).
  - `requestReg` to `VALID_DREQ`: 1 cycle.
- DACK timing: asserts on the cycle after `dackEn` and deasserts on the cycle after `cycleDone`.
- Re-arbitration: the earliest new grant is on the cycle after DONE, i.e. 2 cycles after `cycleDone`.
- Simultaneous requests: resolved strictly by priority order. A new request arriving during SVC or DONE waits in IDLE.
- Reset asserted mid-SVC: all outputs return to reset values asynchronously and the grant is lost.

## Structure
- Shared package `dma_pkg`:
  - `arb_state_t` enum {IDLE, REQ, SVC, DONE}.
  - `NUM_CH` constant.
  - Function `prio_pick(eff, ptr)` returning the index.
- Sub-module `dma_dreq_sync`: 2-flop synchronizer, parameterized by width, instantiated once for NUM_CH bits.

## Test plan
- Fixed priority, DREQ = 4'b1010 held, mask 0: `VALID_DREQ` = 4'b0010 three cycles later; after `dackEn`, DACK = 4'b1101.
- Rotating priority: after servicing ch1, drive DREQ = 4'b0101. ch2 wins and `prioPtr` = 2; after ch2 completes, ch0 is granted before ch1.
- Mask ch3 with DREQ[3] = 1: no grant. Set `requestReg[3]` = 1: grant within 1 cycle. `cycleDone` with `tcHit` = 1: `clrSoftReq` = 4'b1000 for one cycle.
- Drop DREQ[0] in REQ before `dackEn`: `VALID_DREQ` returns to 0 and the FSM is in IDLE; a later `dackEn` produces no DACK.
- With `cmdDackHigh` = 1 and `cmdDreqLow` = 1, drive DREQ pins = 4'b1110: ch0 is granted and DACK = 4'b0001 in SVC. Assert `cmdDisable` mid-SVC: the cycle completes and no new grant follows.
- Pulse `RESET_N` low in SVC: DACK = 4'hF, `VALID_DREQ` = 0 and `prioPtr` = 0 immediately.

Source files
------------

// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA channel request resolver.
//   NUM_CH       : number of DMA channels (design is built for 4)
//   arb_state_t  : arbitration FSM states
//   prio_pick()  : index of the first requesting channel, scanning upward
//                  from the priority pointer with modulo-4 wrap
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    // The 2-bit index wraps naturally, so ptr + i walks ptr, ptr+1, ... mod 4.
    function automatic logic [1:0] prio_pick(input logic [NUM_CH-1:0] eff,
                                             input logic [1:0]        ptr);
        logic [1:0] idx;
        logic       found;
        prio_pick = ptr;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + 2'(i);
            if (!found && eff[idx]) begin
                prio_pick = idx;
                found     = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/dma_dreq_sync.sv
// ---------------------------------------------------------------------------
// dma_dreq_sync
// Two-flop synchronizer bringing the asynchronous DREQ pins into CLK.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, clears both stages
//   din   : raw asynchronous inputs
//   dout  : synchronized outputs (two cycles of latency)
// ---------------------------------------------------------------------------
module dma_dreq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
// Channel request resolver for an 8237A-style DMA controller. Merges the
// synchronized DREQ pins with mask and software request registers, picks one
// channel under fixed or rotating priority, and holds that grant until the
// timing control reports the end of the transfer cycle.
//   CLK, RESET_N  : clock, asynchronous active-low reset
//   DREQ          : raw channel request pins (asynchronous)
//   maskReg       : 1 = hardware request of that channel masked
//   requestReg    : software requests (unmasked, unsynchronized)
//   cmdDisable    : 1 = no new arbitration
//   cmdRotate     : 0 = fixed priority (ch0 highest), 1 = rotating
//   cmdDreqLow    : 1 = DREQ pins active-low
//   cmdDackHigh   : 1 = DACK pins active-high
//   dackEn        : pulse, timing control owns the bus (S1)
//   cycleDone     : pulse, end of S4 or EOP
//   tcHit         : qualifies cycleDone, terminal count on active channel
//   VALID_DREQ    : registered one-hot granted channel
//   DACK          : acknowledge pins
//   activeCh      : index of granted channel
//   reqStatus     : synchronized effective requests
//   clrSoftReq    : one-cycle pulse to clear a software request bit on TC
// ---------------------------------------------------------------------------
module dma_priority_arbiter #(
    parameter int NUM_CH = dma_pkg::NUM_CH
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] requestReg,
    input  logic              cmdDisable,
    input  logic              cmdRotate,
    input  logic              cmdDreqLow,
    input  logic              cmdDackHigh,
    input  logic              dackEn,
    input  logic              cycleDone,
    input  logic              tcHit,
    output logic [NUM_CH-1:0] VALID_DREQ,
    output logic [NUM_CH-1:0] DACK,
    output logic [1:0]        activeCh,
    output logic [NUM_CH-1:0] reqStatus,
    output logic [NUM_CH-1:0] clrSoftReq
);

    import dma_pkg::*;

    logic [NUM_CH-1:0] sync_req;
    logic [NUM_CH-1:0] hw_req;
    logic [NUM_CH-1:0] eff;

    arb_state_t        state_q,    state_d;
    logic [1:0]        active_ch_q, active_ch_d;
    logic [1:0]        prio_ptr_q,  prio_ptr_d;
    logic [NUM_CH-1:0] valid_q,     valid_d;
    logic [NUM_CH-1:0] dack_vec_q,  dack_vec_d;
    logic [NUM_CH-1:0] clr_soft_q,  clr_soft_d;

    dma_dreq_sync #(
        .WIDTH (NUM_CH)
    ) u_dreq_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (DREQ),
        .dout  (sync_req)
    );

    // Polarity is applied after synchronization so a cmdDreqLow change takes
    // effect immediately rather than rippling through the sync stages.
    assign hw_req = sync_req ^ {NUM_CH{cmdDreqLow}};
    assign eff    = (hw_req & ~maskReg) | requestReg;

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        valid_d     = valid_q;
        dack_vec_d  = dack_vec_q;
        clr_soft_d  = '0;
        // Fixed priority pins the pointer at ch0.
        prio_ptr_d  = cmdRotate ? prio_ptr_q : 2'd0;

        case (state_q)
            IDLE: begin
                if (!cmdDisable && (eff != '0)) begin
                    active_ch_d = prio_pick(eff, prio_ptr_q);
                    valid_d     = NUM_CH'(1) << active_ch_d;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // A request withdrawn before the bus is granted cancels the
                // arbitration; withdrawal wins over a same-cycle dackEn.
                if (!eff[active_ch_q]) begin
                    valid_d = '0;
                    state_d = IDLE;
                end else if (dackEn) begin
                    dack_vec_d = valid_q;
                    state_d    = SVC;
                end
            end
            SVC: begin
                // Outputs and the pointer/clear pulse are registered on the
                // transition so they are already in effect during DONE.
                if (cycleDone) begin
                    valid_d    = '0;
                    dack_vec_d = '0;
                    state_d    = DONE;
                    if (cmdRotate) begin
                        prio_ptr_d = active_ch_q + 2'd1;
                    end
                    if (tcHit) begin
                        clr_soft_d = valid_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            active_ch_q <= 2'd0;
            prio_ptr_q  <= 2'd0;
            valid_q     <= '0;
            dack_vec_q  <= '0;
            clr_soft_q  <= '0;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            prio_ptr_q  <= prio_ptr_d;
            valid_q     <= valid_d;
            dack_vec_q  <= dack_vec_d;
            clr_soft_q  <= clr_soft_d;
        end
    end

    assign VALID_DREQ = valid_q;
    assign DACK       = cmdDackHigh ? dack_vec_q : ~dack_vec_q;
    assign activeCh   = active_ch_q;
    assign reqStatus  = eff;
    assign clrSoftReq = clr_soft_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_arbiter
// Directed stimulus pushes expected output events ({kind, value, cycle}) into
// a queue; a monitor on the falling edge detects every change of
// {activeCh,VALID_DREQ}, DACK and clrSoftReq and pops/compares.
// ---------------------------------------------------------------------------
module tb_dma_priority_arbiter;

    localparam int K_VALID = 0;
    localparam int K_DACK  = 1;
    localparam int K_CLR   = 2;

    typedef struct {
        int         kind;
        logic [5:0] val;
        int         cyc;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ, maskReg, requestReg;
    logic       cmdDisable, cmdRotate, cmdDreqLow, cmdDackHigh;
    logic       dackEn, cycleDone, tcHit;
    logic [3:0] VALID_DREQ, DACK, reqStatus, clrSoftReq;
    logic [1:0] activeCh;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];
    logic [5:0] prev_v, prev_d, prev_c;

    dma_priority_arbiter #(.NUM_CH(4)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .DREQ        (DREQ),
        .maskReg     (maskReg),
        .requestReg  (requestReg),
        .cmdDisable  (cmdDisable),
        .cmdRotate   (cmdRotate),
        .cmdDreqLow  (cmdDreqLow),
        .cmdDackHigh (cmdDackHigh),
        .dackEn      (dackEn),
        .cycleDone   (cycleDone),
        .tcHit       (tcHit),
        .VALID_DREQ  (VALID_DREQ),
        .DACK        (DACK),
        .activeCh    (activeCh),
        .reqStatus   (reqStatus),
        .clrSoftReq  (clrSoftReq)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_VALID: kname = "valid";
            K_DACK:  kname = "dack";
            default: kname = "clr";
        endcase
    endfunction

    task automatic observe(input int kind, input logic [5:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event at cycle %0d: got %b, required none", kname(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
                errors++;
                $display("FAIL %s event: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if ({activeCh, VALID_DREQ} !== prev_v) observe(K_VALID, {activeCh, VALID_DREQ});
            if ({2'b00, DACK} !== prev_d)          observe(K_DACK,  {2'b00, DACK});
            if ({2'b00, clrSoftReq} !== prev_c)    observe(K_CLR,   {2'b00, clrSoftReq});
        end
        prev_v <= {activeCh, VALID_DREQ};
        prev_d <= {2'b00, DACK};
        prev_c <= {2'b00, clrSoftReq};
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Expected event 'off' clock edges after the most recent edge.
    task automatic ex(input int kind, input logic [5:0] val, input int off);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc + off;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic pulse_dack();
        dackEn = 1'b1;
        step(1);
        dackEn = 1'b0;
    endtask

    task automatic pulse_done(input logic tc);
        cycleDone = 1'b1;
        tcHit     = tc;
        step(1);
        cycleDone = 1'b0;
        tcHit     = 1'b0;
    endtask

    initial begin
        ev_t e;
        RESET_N = 1'b0;
        DREQ = '0; maskReg = '0; requestReg = '0;
        cmdDisable = 1'b0; cmdRotate = 1'b0; cmdDreqLow = 1'b0; cmdDackHigh = 1'b0;
        dackEn = 1'b0; cycleDone = 1'b0; tcHit = 1'b0;

        // Reset state
        step(3);
        chk("reset_valid",     {2'b00, VALID_DREQ}, 6'b000000);
        chk("reset_dack",      {2'b00, DACK},       6'b001111);
        chk("reset_activech",  {4'b0000, activeCh}, 6'b000000);
        chk("reset_clr",       {2'b00, clrSoftReq}, 6'b000000);
        chk("reset_reqstatus", {2'b00, reqStatus},  6'b000000);
        RESET_N = 1'b1;
        step(2);
        mon_en = 1'b1;
        step(1);

        // Fixed priority, DREQ=1010: ch1 three edges later, DACK=1101
        DREQ = 4'b1010;
        ex(K_VALID, {2'd1, 4'b0010}, 3);
        step(2);
        chk("sync_reqstatus", {2'b00, reqStatus}, 6'b001010);
        step(1);
        ex(K_DACK, {2'b00, 4'b1101}, 1);
        pulse_dack();
        step(2);
        ex(K_VALID, {2'd1, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        DREQ = 4'b0000;
        pulse_done(1'b0);
        step(4);
        // Strobes outside their states are ignored
        pulse_dack();
        step(1);
        pulse_done(1'b0);
        step(3);

        // Rotating priority
        cmdRotate = 1'b1;
        DREQ = 4'b0010;
        ex(K_VALID, {2'd1, 4'b0010}, 3);
        step(3);
        ex(K_DACK, {2'b00, 4'b1101}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd1, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        ex(K_VALID, {2'd2, 4'b0100}, 3);   // pointer 2: ch2 beats ch0
        DREQ = 4'b0101;
        pulse_done(1'b0);
        step(2);
        ex(K_DACK, {2'b00, 4'b1011}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd2, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        ex(K_VALID, {2'd0, 4'b0001}, 3);   // pointer 3: ch0 before ch1
        DREQ = 4'b0011;
        pulse_done(1'b0);
        step(2);
        ex(K_DACK, {2'b00, 4'b1110}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd0, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        ex(K_VALID, {2'd1, 4'b0010}, 3);   // pointer 1: ch1 beats ch0
        pulse_done(1'b0);
        step(2);
        ex(K_DACK, {2'b00, 4'b1101}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd1, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        DREQ = 4'b0000;
        pulse_done(1'b0);
        step(4);
        cmdRotate = 1'b0;
        step(2);

        // Masked hardware request, then software request with TC
        maskReg = 4'b1000;
        DREQ    = 4'b1000;
        step(4);
        chk("masked_reqstatus", {2'b00, reqStatus}, 6'b000000);
        requestReg = 4'b1000;
        ex(K_VALID, {2'd3, 4'b1000}, 1);
        #1;
        chk("softreq_reqstatus", {2'b00, reqStatus}, 6'b001000);
        step(1);
        ex(K_DACK, {2'b00, 4'b0111}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd3, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        ex(K_CLR,   {2'b00, 4'b1000}, 1);
        ex(K_CLR,   {2'b00, 4'b0000}, 2);
        pulse_done(1'b1);
        requestReg = 4'b0000;
        step(3);
        DREQ = 4'b0000;
        step(3);
        maskReg = 4'b0000;
        step(2);

        // Withdrawal in REQ; a later dackEn gives no DACK
        DREQ = 4'b0001;
        ex(K_VALID, {2'd0, 4'b0001}, 3);
        step(3);
        DREQ = 4'b0000;
        ex(K_VALID, {2'd0, 4'b0000}, 3);
        step(4);
        pulse_dack();
        step(3);

        // Active-low DREQ, active-high DACK, cmdDisable mid-SVC
        cmdDisable  = 1'b1;
        DREQ        = 4'b1111;
        cmdDreqLow  = 1'b1;
        cmdDackHigh = 1'b1;
        ex(K_DACK, {2'b00, 4'b0000}, 0);
        step(3);
        cmdDisable = 1'b0;
        step(1);
        DREQ = 4'b1110;
        ex(K_VALID, {2'd0, 4'b0001}, 3);
        step(3);
        chk("lowpin_reqstatus", {2'b00, reqStatus}, 6'b000001);
        ex(K_DACK, {2'b00, 4'b0001}, 1);
        pulse_dack();
        step(1);
        cmdDisable = 1'b1;
        step(2);
        ex(K_VALID, {2'd0, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b0000}, 1);
        pulse_done(1'b0);
        step(6);
        DREQ = 4'b0000;
        step(3);
        cmdDreqLow  = 1'b0;
        cmdDackHigh = 1'b0;
        ex(K_DACK, {2'b00, 4'b1111}, 0);
        step(1);
        cmdDisable = 1'b0;
        step(3);

        // Reset in SVC with a non-zero rotation pointer
        cmdRotate = 1'b1;
        DREQ = 4'b0010;
        ex(K_VALID, {2'd1, 4'b0010}, 3);
        step(3);
        ex(K_DACK, {2'b00, 4'b1101}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd1, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        DREQ = 4'b0000;
        pulse_done(1'b0);
        step(4);
        DREQ = 4'b0100;
        ex(K_VALID, {2'd2, 4'b0100}, 3);
        step(3);
        ex(K_DACK, {2'b00, 4'b1011}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd0, 4'b0000}, 0);
        ex(K_DACK,  {2'b00, 4'b1111}, 0);
        RESET_N = 1'b0;
        #1;
        chk("rst_svc_valid",    {2'b00, VALID_DREQ}, 6'b000000);
        chk("rst_svc_dack",     {2'b00, DACK},       6'b001111);
        chk("rst_svc_activech", {4'b0000, activeCh}, 6'b000000);
        DREQ = 4'b0110;
        step(1);
        RESET_N = 1'b1;
        ex(K_VALID, {2'd1, 4'b0010}, 3);   // pointer back at 0: ch1 beats ch2
        step(3);
        ex(K_DACK, {2'b00, 4'b1101}, 1);
        pulse_dack();
        step(1);
        ex(K_VALID, {2'd1, 4'b0000}, 1);
        ex(K_DACK,  {2'b00, 4'b1111}, 1);
        DREQ = 4'b0000;
        pulse_done(1'b0);
        step(6);

        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing event: got none, required %b at cycle %0d", kname(e.kind), e.val, e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
